i2c_master_byte: RTL

I2C_MASTER_BYTE -- requirements
Module: i2c_master_byte

---
 rtl/i2c_master_byte.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: START/WRITE/READ/STOP, 4*CLK_DIV cycles per bit; done 4*CLK_DIV (START/STOP) or 36*CLK_DIV (WRITE/READ) after accept.
// Backpressure: cmd_ready low from accept until the done cycle; cmd_valid ignored meanwhile.
module i2c_master_byte #(
  parameter int CLK_DIV = 125
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_ack,
  output logic       cmd_ready,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       ack_rcvd,
  output logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_en
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WRITE, S_READ, S_STOP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_tick;
  logic [1:0]      r_q;
  logic [3:0]      r_bit;
  logic [7:0]      r_wdata;
  logic            r_rd_ack;
  logic [7:0]      r_shift;
  logic            r_ack_smp;
  logic            r_idle_scl;
  logic            r_idle_en;
  logic            r_done;
  logic [7:0]      r_rd_data;
  logic            r_ack_rcvd;

  logic            w_qend;
  logic            w_bitend;
  logic            w_last;
  logic            w_data_st;
  logic [2:0]      w_bit_idx;
  logic            w_bit_en;
  logic            w_scl;
  logic            w_sda_en;
  logic            w_cmd_ready;

  assign w_qend    = (r_tick == TICK_MAX);
  assign w_bitend  = w_qend && (r_q == 2'd3);
  assign w_data_st = (r_state == S_WRITE) || (r_state == S_READ);
  assign w_last    = w_bitend && (!w_data_st || (r_bit == 4'd8));
  assign w_bit_idx = 3'd7 - r_bit[2:0];

  // SDA drive for the current data bit; bit 8 is the acknowledge slot.
  always_comb begin
    w_bit_en = 1'b0;
    if (r_state == S_WRITE) begin
      w_bit_en = (r_bit == 4'd8) ? 1'b0 : ~r_wdata[w_bit_idx];
    end else if (r_state == S_READ) begin
      w_bit_en = (r_bit == 4'd8) ? ~r_rd_ack : 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            2'b00:   w_next = S_START;
            2'b01:   w_next = S_WRITE;
            2'b10:   w_next = S_READ;
            default: w_next = S_STOP;
          endcase
        end
      end
      default: begin
        if (w_last) w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_cmd_ready = 1'b0;
    w_scl       = 1'b1;
    w_sda_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        w_scl       = r_idle_scl;
        w_sda_en    = r_idle_en;
      end
      S_START: begin
        w_scl    = (r_q == 2'd1) || (r_q == 2'd2);
        w_sda_en = r_q[1];
      end
      S_STOP: begin
        w_scl    = (r_q != 2'd0);
        w_sda_en = ~r_q[1];
      end
      default: begin
        w_scl    = (r_q == 2'd1) || (r_q == 2'd2);
        w_sda_en = w_bit_en;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tick     <= '0;
      r_q        <= 2'd0;
      r_bit      <= 4'd0;
      r_wdata    <= 8'h00;
      r_rd_ack   <= 1'b0;
      r_shift    <= 8'h00;
      r_ack_smp  <= 1'b0;
      r_idle_scl <= 1'b1;
      r_idle_en  <= 1'b0;
      r_done     <= 1'b0;
      r_rd_data  <= 8'h00;
      r_ack_rcvd <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_tick <= '0;
        r_q    <= 2'd0;
        r_bit  <= 4'd0;
        if (cmd_valid) begin
          r_wdata  <= wr_data;
          r_rd_ack <= rd_ack;
        end
      end else begin
        r_tick <= w_qend ? '0 : r_tick + 1'b1;
        if (w_qend)   r_q   <= r_q + 2'd1;
        if (w_bitend) r_bit <= r_bit + 4'd1;
        // SDA is sampled as the high phase of SCL reaches its midpoint.
        if (w_data_st && w_qend && (r_q == 2'd1)) begin
          if (r_bit == 4'd8) r_ack_smp <= sda_in;
          else               r_shift   <= {r_shift[6:0], sda_in};
        end
        if (w_last) begin
          r_done     <= 1'b1;
          r_idle_scl <= w_scl;
          r_idle_en  <= w_sda_en;
          if (r_state == S_READ)  r_rd_data  <= r_shift;
          if (r_state == S_WRITE) r_ack_rcvd <= r_ack_smp;
        end
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign done      = r_done;
  assign rd_data   = r_rd_data;
  assign ack_rcvd  = r_ack_rcvd;
  assign scl       = w_scl;
  assign sda_en    = w_sda_en;
  assign sda_out   = 1'b0;

endmodule
